pipe_stage_buffer: RTL and testbench

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

---
 rtl/pipe_stage_buffer.sv | 111 +++++++++++
 tb/tb_pipe_stage_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer pipeline stage: MAIN drives the output, SKID catches the one
// entry accepted while the downstream stalls. IN_READY is registered off the next state.
module pipe_stage_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FIELDS = 6
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     FLUSH,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [FIELDS*DATA_W-1:0] IN_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [FIELDS*DATA_W-1:0] OUT_DATA,
  output logic [1:0]               OCCUPANCY,
  output logic [7:0]               FLUSH_CNT
);

  localparam int unsigned Width = FIELDS * DATA_W;

  typedef enum logic [1:0] {StEmpty, StHalf, StFull} state_e;

  state_e             state_q, state_d;
  logic [Width-1:0]   main_q, main_d;
  logic [Width-1:0]   skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         occ_q, occ_d;
  logic [7:0]         flush_cnt_q, flush_cnt_d;
  logic               accept;
  logic               xfer;
  logic [8:0]         cnt_sum;

  always_comb begin
    accept      = IN_VALID & in_ready_q;
    xfer        = out_valid_q & OUT_READY;
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    flush_cnt_d = flush_cnt_q;
    cnt_sum     = {1'b0, flush_cnt_q} + {7'b0, occ_q};

    if (FLUSH) begin
      // Flush wins over any handshake in the same cycle.
      state_d     = StEmpty;
      flush_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = IN_DATA;
            state_d = StHalf;
          end
        end
        StHalf: begin
          if (accept && xfer) begin
            main_d = IN_DATA;
          end else if (accept) begin
            skid_d  = IN_DATA;
            state_d = StFull;
          end else if (xfer) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (xfer) begin
            main_d  = skid_q;
            state_d = StHalf;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    in_ready_d  = (state_d != StFull);
    out_valid_d = (state_d != StEmpty);
    unique case (state_d)
      StHalf:  occ_d = 2'd1;
      StFull:  occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      flush_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = main_q;
  assign OCCUPANCY = occ_q;
  assign FLUSH_CNT = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Randomized + directed bench for pipe_stage_buffer against a queue-based reference model.
module tb_pipe_stage_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic [1:0]  occupancy;
  logic [7:0]  flush_cnt;

  logic        in_valid8;
  logic        in_ready8;
  logic [23:0] in_data8;
  logic        out_valid8;
  logic        out_ready8;
  logic [23:0] out_data8;
  logic [1:0]  occupancy8;
  logic [7:0]  flush_cnt8;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [95:0] mq[$];
  int          m_cnt = 0;

  pipe_stage_buffer u_dut (
    .CLK       (clk),
    .RST       (rst_n),
    .FLUSH     (flush),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
    .OCCUPANCY (occupancy),
    .FLUSH_CNT (flush_cnt)
  );

  pipe_stage_buffer #(
    .DATA_W (8),
    .FIELDS (3)
  ) u_dut8 (
    .CLK       (clk),
    .RST       (rst_n),
    .FLUSH     (1'b0),
    .IN_VALID  (in_valid8),
    .IN_READY  (in_ready8),
    .IN_DATA   (in_data8),
    .OUT_VALID (out_valid8),
    .OUT_READY (out_ready8),
    .OUT_DATA  (out_data8),
    .OCCUPANCY (occupancy8),
    .FLUSH_CNT (flush_cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = mq.size();
    check_eq({tag, ".out_valid"}, 128'(out_valid), 128'(sz > 0));
    check_eq({tag, ".in_ready"}, 128'(in_ready), 128'(sz < 2));
    check_eq({tag, ".occupancy"}, 128'(occupancy), 128'(sz));
    check_eq({tag, ".flush_cnt"}, 128'(flush_cnt), 128'(m_cnt));
    if (sz > 0) check_eq({tag, ".out_data"}, 128'(out_data), 128'(mq[0]));
  endtask

  // Drive one cycle of inputs, advance the model by the same handshake rules, check after edge.
  task automatic step(input string tag, input logic v, input logic [95:0] d, input logic r,
                      input logic f);
    int sz;
    sz        = mq.size();
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    if (f) begin
      m_cnt = (m_cnt + sz > 255) ? 255 : m_cnt + sz;
      mq.delete();
    end else begin
      if (r && sz > 0) void'(mq.pop_front());
      if (v && sz < 2) mq.push_back(d);
    end
    @(negedge clk);
    check_state(tag);
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [95:0] a;
    logic [95:0] b;
    logic [95:0] inc;
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    in_valid8  = 1'b0;
    in_data8   = '0;
    out_ready8 = 1'b0;
    @(negedge clk);
    check_state("reset");
    check_eq("reset.out_data_zero", 128'(out_data), 128'd0);
    rst_n = 1'b1;

    // Single entry with fields 1..6.
    a = {16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
    step("basic", 1'b1, a, 1'b1, 1'b0);
    check_eq("basic.data_literal", 128'(out_data), 128'(a));
    step("basic_drain", 1'b0, '0, 1'b1, 1'b0);

    // Fill with A then B under stall, then drain in order.
    a = {96{1'b1}};
    b = '0;
    step("fill_a", 1'b1, a, 1'b0, 1'b0);
    step("fill_b", 1'b1, b, 1'b0, 1'b0);
    check_eq("full.in_ready_low", 128'(in_ready), 128'd0);
    step("full_hold", 1'b0, '0, 1'b0, 1'b0);
    check_eq("full_hold.a_stable", 128'(out_data), 128'(a));
    step("drain_a", 1'b0, '0, 1'b1, 1'b0);
    check_eq("drain_a.in_ready_back", 128'(in_ready), 128'd1);
    step("drain_b", 1'b0, '0, 1'b1, 1'b0);

    // Sustained streaming through HALF.
    inc = 96'd100;
    step("stream_load", 1'b1, inc, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step("stream", 1'b1, inc + 96'(i), 1'b1, 1'b0);
      check_eq("stream.occ_one", 128'(occupancy), 128'd1);
      check_eq("stream.data_seq", 128'(out_data), 128'(inc + 96'(i)));
    end
    step("stream_drain", 1'b0, '0, 1'b1, 1'b0);

    // Flush while FULL with a concurrent offer.
    step("pre_flush_1", 1'b1, rnd96(), 1'b0, 1'b0);
    step("pre_flush_2", 1'b1, rnd96(), 1'b0, 1'b0);
    step("flush_full", 1'b1, 96'hDEAD, 1'b1, 1'b1);
    check_eq("flush_full.cnt_two", 128'(flush_cnt), 128'd2);
    step("post_flush", 1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges while FULL.
    step("pre_rst_1", 1'b1, rnd96(), 1'b0, 1'b0);
    step("pre_rst_2", 1'b1, rnd96(), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    mq.delete();
    m_cnt = 0;
    #1 check_state("async_rst");
    check_eq("async_rst.out_data_zero", 128'(out_data), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a = rnd96();
    step("post_rst_accept", 1'b1, a, 1'b0, 1'b0);
    check_eq("post_rst.data", 128'(out_data), 128'(a));
    step("post_rst_drain", 1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      step("random", 1'($urandom_range(1)), rnd96(), 1'($urandom_range(1)),
           ($urandom_range(15) == 0));
    end

    // Drive flush counter into saturation.
    for (int i = 0; i < 130; i++) begin
      step("sat_fill1", 1'b1, rnd96(), 1'b0, 1'b0);
      step("sat_fill2", 1'b1, rnd96(), 1'b0, 1'b0);
      step("sat_flush", 1'b0, '0, 1'b0, 1'b1);
    end
    check_eq("sat.cnt_255", 128'(flush_cnt), 128'd255);

    // Narrow configuration: 3 fields of 8 bits.
    in_valid8 = 1'b1;
    in_data8  = 24'hA5C33C;
    @(negedge clk);
    in_valid8 = 1'b0;
    check_eq("narrow.out_valid", 128'(out_valid8), 128'd1);
    check_eq("narrow.out_data", 128'(out_data8), 128'hA5C33C);
    check_eq("narrow.field0", 128'(out_data8[7:0]), 128'h3C);
    check_eq("narrow.occ", 128'(occupancy8), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
